div_ctrl: RTL



---
 rtl/div_ctrl_if.sv | 35 +++
 rtl/div_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/div_ctrl_if.sv
// Handshake bundle between the execute-stage pipeline, the divider controller
// and the multi-cycle unsigned divider.
interface div_ctrl_if #(
  parameter int W = 32
);
  logic           req_valid;
  logic           req_signed;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;
  logic           wr_hi;
  logic           wr_lo;
  logic [W-1:0]   wr_data;
  logic           flush;
  logic           busy;
  logic           resp_valid;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic           div_valid;
  logic [W-1:0]   div_a;
  logic [W-1:0]   div_b;
  logic           div_done;
  logic [2*W-1:0] div_c;

  modport slave (
    input  req_valid, req_signed, req_a, req_b, wr_hi, wr_lo, wr_data, flush,
    input  div_done, div_c,
    output busy, resp_valid, hi, lo, div_valid, div_a, div_b
  );

  modport master (
    output req_valid, req_signed, req_a, req_b, wr_hi, wr_lo, wr_data, flush,
    output div_done, div_c,
    input  busy, resp_valid, hi, lo, div_valid, div_a, div_b
  );
endinterface

// File: rtl/div_ctrl.sv
// Execute-stage initiator for the multi-cycle unsigned divider: signed
// pre/post-processing, HI/LO ownership, pipeline stall and flush handling.
module div_ctrl #(
  parameter int W = 32
) (
  input  logic       clk,
  input  logic       resetn,
  div_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DRAIN   = 3'd4,
    DZERO   = 3'd5
  } state_t;

  state_t       state_q;
  logic [W-1:0] hi_q;
  logic [W-1:0] lo_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         q_neg_q;
  logic         r_neg_q;

  logic [W-1:0] quot_d;
  logic [W-1:0] rem_d;

  function automatic logic [W-1:0] neg2c(input logic [W-1:0] x);
    return ~x + {{(W-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of a signed operand; 0x80..0 maps to itself read as unsigned.
  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
    logic signed [W-1:0] xs;
    xs = signed'(x);
    return (sgn && (xs < 0)) ? neg2c(x) : x;
  endfunction

  assign quot_d = q_neg_q ? neg2c(bus.div_c[W-1:0])   : bus.div_c[W-1:0];
  assign rem_d  = r_neg_q ? neg2c(bus.div_c[2*W-1:W]) : bus.div_c[2*W-1:W];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.wr_hi) hi_q <= bus.wr_data;
          if (bus.wr_lo) lo_q <= bus.wr_data;
          if (bus.req_valid) begin
            if (bus.req_b != '0) begin
              a_q     <= mag(bus.req_a, bus.req_signed);
              b_q     <= mag(bus.req_b, bus.req_signed);
              q_neg_q <= bus.req_signed & (bus.req_a[W-1] ^ bus.req_b[W-1]);
              r_neg_q <= bus.req_signed & bus.req_a[W-1];
              state_q <= LAUNCH;
            end else begin
              state_q <= DZERO;
            end
          end
        end
        // div_done is still high from the previous op here, so it is not looked at.
        LAUNCH:  state_q <= bus.flush ? IDLE : WAIT;
        WAIT: begin
          if (bus.flush)         state_q <= DRAIN;
          else if (bus.div_done) state_q <= CAPTURE;
        end
        CAPTURE: begin
          if (!bus.flush) begin
            lo_q <= quot_d;
            hi_q <= rem_d;
          end
          state_q <= IDLE;
        end
        DRAIN: if (bus.div_done) state_q <= IDLE;
        DZERO:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.div_valid  = (state_q == LAUNCH) && !bus.flush;
  assign bus.resp_valid = ((state_q == CAPTURE) || (state_q == DZERO)) && !bus.flush;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.div_a      = a_q;
  assign bus.div_b      = b_q;

endmodule
